// File: rtl/rf_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package rf_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ZERO     = 0;

  // Low bit of port 'port' inside a flat bus of 'width'-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: issue sets, writeback clears, issue wins a tie.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NWP  = 1,
  parameter int NRP  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   wa,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP-1:0]      rbusy,
  output logic [NREG-1:0]     busy_vec
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next scoreboard state; a new producer supersedes a retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      for (int i = 0; i < NWP; i++) begin
        if (we[i] && wa[slice_lo(i, AW) +: AW] == AW'(r)) busy_d[r] = 1'b0;
      end
      if (iss_valid && iss_rd == AW'(r)) busy_d[r] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Scoreboard register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  for (genvar j = 0; j < NRP; j++) begin : g_rbusy
    logic [AW-1:0] addr;
    logic          wr_hit;
    assign addr = ra[slice_lo(j, AW) +: AW];

    // A same-cycle writeback to the read register hides its busy bit.
    always_comb begin
      wr_hit = 1'b0;
      for (int i = 0; i < NWP; i++) begin
        if (we[i] && wa[slice_lo(i, AW) +: AW] == addr) wr_hit = 1'b1;
      end
    end

    assign rbusy[j] = busy_q[addr] && !wr_hit;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-through bypass and busy scoreboard.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   wa,
  input  logic [NWP*XLEN-1:0] wd,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREG-1:0]     busy_vec
);

  if (NREG != 2 ** AW) begin : g_bad_nreg
    $error("regfile_sb: NREG must be a power of two");
  end
  if (NWP < 1 || NWP > 4) begin : g_bad_nwp
    $error("regfile_sb: NWP must be 1..4");
  end

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // Apply writes in port order so the highest-index port wins an address clash.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NWP; i++) begin
      if (we[i] && int'(wa[slice_lo(i, AW) +: AW]) != REG_ZERO)
        regs_d[wa[slice_lo(i, AW) +: AW]] = wd[slice_lo(i, XLEN) +: XLEN];
    end
    regs_d[REG_ZERO] = '0;
  end

  // Storage array, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar j = 0; j < NRP; j++) begin : g_read
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;
    assign addr = ra[slice_lo(j, AW) +: AW];

    // Read mux with write-through bypass; x0 and reset force zero.
    always_comb begin
      val = regs_q[addr];
      for (int i = 0; i < NWP; i++) begin
        if (we[i] && wa[slice_lo(i, AW) +: AW] == addr)
          val = wd[slice_lo(i, XLEN) +: XLEN];
      end
      if (rst || int'(addr) == REG_ZERO) val = '0;
    end

    assign rdata[slice_lo(j, XLEN) +: XLEN] = val;
  end

  rf_scoreboard #(
    .NREG(NREG),
    .NWP (NWP),
    .NRP (NRP),
    .AW  (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wa       (wa),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .ra       (ra),
    .rbusy    (rbusy),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised self-checking bench for regfile_sb against an architectural model.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int AW   = 5;

  logic                clk;
  logic                rst;
  logic [NWP-1:0]      we;
  logic [NWP*AW-1:0]   wa;
  logic [NWP*XLEN-1:0] wd;
  logic [NRP*AW-1:0]   ra;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [NREG-1:0]     busy_vec;

  int assertCount = 0;
  int failCount   = 0;

  // Architectural state as software sees it: register values and pending producers.
  logic [XLEN-1:0] mReg  [NREG];
  bit              mBusy [NREG];

  regfile_sb #(
    .XLEN(XLEN),
    .NREG(NREG),
    .NRP (NRP),
    .NWP (NWP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .ra       (ra),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .busy_vec (busy_vec)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Wipe the model the way an asynchronous reset wipes the design.
  task automatic resetModel();
    for (int r = 0; r < NREG; r++) begin
      mReg[r]  = '0;
      mBusy[r] = 1'b0;
    end
  endtask

  // True when some enabled write port targets address a this cycle.
  function automatic bit anyWrite(input int a);
    bit hit = 1'b0;
    for (int i = 0; i < NWP; i++)
      if (we[i] && int'(wa[i*AW +: AW]) == a) hit = 1'b1;
    return hit;
  endfunction

  // Value software expects to read: latest same-cycle write, else stored value.
  function automatic logic [XLEN-1:0] expRead(input int a);
    logic [XLEN-1:0] v;
    if (rst || a == 0) return '0;
    v = mReg[a];
    for (int i = 0; i < NWP; i++)
      if (we[i] && int'(wa[i*AW +: AW]) == a) v = wd[i*XLEN +: XLEN];
    return v;
  endfunction

  // Compare every output of the design against the model for the current inputs.
  task automatic checkCycle();
    logic [NREG-1:0] expBusy;
    for (int j = 0; j < NRP; j++) begin
      int a = int'(ra[j*AW +: AW]);
      checkOutput($sformatf("rdata%0d(ra=%0d)", j, a), rdata[j*XLEN +: XLEN], expRead(a));
      checkOutput($sformatf("rbusy%0d(ra=%0d)", j, a), {31'b0, rbusy[j]},
                  {31'b0, (!rst && mBusy[a] && !anyWrite(a))});
    end
    for (int r = 0; r < NREG; r++) expBusy[r] = mBusy[r];
    checkOutput("busy_vec", busy_vec, expBusy);
  endtask

  // Retire one clock edge into the model: writes land, writebacks clear, issues set.
  task automatic commitModel();
    if (rst) return;
    for (int i = 0; i < NWP; i++) begin
      int a = int'(wa[i*AW +: AW]);
      if (we[i] && a != 0) begin
        mReg[a]  = wd[i*XLEN +: XLEN];
        mBusy[a] = 1'b0;
      end
    end
    if (iss_valid && iss_rd != '0) mBusy[iss_rd] = 1'b1;
  endtask

  // Drive one cycle of inputs just after a falling edge, check, then clock it in.
  task automatic applyStimulus(input bit rstV, input logic [1:0] weV,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input bit issV, input logic [4:0] issRd);
    rst       = rstV;
    we        = weV;
    wa        = {wa1, wa0};
    wd        = {wd1, wd0};
    ra        = {ra1, ra0};
    iss_valid = issV;
    iss_rd    = issRd;
    if (rstV) resetModel();
    #1;
    checkCycle();
    @(posedge clk);
    commitModel();
    @(negedge clk);
  endtask

  // Directed scenarios first, then a long randomised run with occasional resets.
  initial begin
    rst = 1'b1; we = '0; wa = '0; wd = '0; ra = '0; iss_valid = 1'b0; iss_rd = '0;
    resetModel();
    @(negedge clk);

    // Held in reset: writes, bypass and issues must all be ignored.
    applyStimulus(1, 2'b01, 5'd5, 32'hCAFEF00D, 5'd0, 32'h0, 5'd5, 5'd0, 1, 5'd5);
    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd6, 0, 5'd0);

    // x0 is never written and never marked busy.
    applyStimulus(0, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1, 5'd0);
    checkOutput("x0_busy", {31'b0, busy_vec[0]}, 32'h0);
    checkOutput("x0_read", rdata[31:0], 32'h0);

    // Write-through bypass, then the stored value on the following cycle.
    applyStimulus(0, 2'b01, 5'd3, 32'h1234, 5'd0, 32'h0, 5'd3, 5'd3, 0, 5'd0);
    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0, 0, 5'd0);

    // Two ports writing one register: the higher port's data wins.
    applyStimulus(0, 2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 5'd7, 5'd3, 0, 5'd0);
    we = '0; ra = {5'd0, 5'd7}; #1;
    checkOutput("dual_write_reg7", rdata[31:0], 32'h2);
    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 0, 5'd0);

    // Issue -> busy next cycle -> writeback hides busy and bypasses -> busy clears.
    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1, 5'd9);
    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 0, 5'd0);
    applyStimulus(0, 2'b10, 5'd0, 32'h0, 5'd9, 32'hABCD, 5'd9, 5'd0, 0, 5'd0);
    checkOutput("busy9_cleared", {31'b0, busy_vec[9]}, 32'h0);

    // Issue and writeback on the same register in one cycle: issue wins.
    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd4);
    applyStimulus(0, 2'b01, 5'd4, 32'h44, 5'd0, 32'h0, 5'd4, 5'd0, 1, 5'd4);
    checkOutput("busy4_kept", {31'b0, busy_vec[4]}, 32'h1);
    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd0, 0, 5'd0);

    // Reset asserted mid-cycle clears data and scoreboard before the next edge.
    applyStimulus(0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd0, 1, 5'd6);
    we = '0; iss_valid = 1'b0; ra = {5'd6, 5'd5}; #1;
    checkOutput("pre_rst_reg5", rdata[31:0], 32'hDEADBEEF);
    rst = 1'b1; resetModel(); #1;
    checkOutput("rst_rdata5", rdata[31:0], 32'h0);
    checkOutput("rst_busy_vec", busy_vec, 32'h0);
    @(posedge clk); @(negedge clk);
    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd6, 0, 5'd0);

    // Random traffic on a narrow address window so clashes and hazards are frequent.
    for (int n = 0; n < 600; n++) begin
      bit         rr   = ($urandom_range(0, 49) == 0);
      logic [4:0] a0   = 5'($urandom_range(0, 7));
      logic [4:0] a1   = 5'($urandom_range(0, 7));
      logic [4:0] r0   = 5'($urandom_range(0, 7));
      logic [4:0] r1   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      logic [4:0] ir   = 5'($urandom_range(0, 7));
      applyStimulus(rr, 2'($urandom_range(0, 3)), a0, $urandom, a1, $urandom,
                    r0, r1, ($urandom_range(0, 2) == 0), ir);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
